// File: rtl/pio_ep_mem_initiator_pkg.sv
// Shared encodings, widths and payload types for the endpoint register-access initiator.
package pio_ep_mem_initiator_pkg;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WBE_W  = 8;
    localparam int unsigned RBE_W  = 4;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned LAT_W  = 3;
    localparam int unsigned ST_W   = 3;

    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_WR_WAIT = 3'd1;
    localparam logic [ST_W-1:0] ST_RD_WAIT = 3'd2;
    localparam logic [ST_W-1:0] ST_RD_CAPT = 3'd3;
    localparam logic [ST_W-1:0] ST_RSP     = 3'd4;

    localparam logic [1:0] REG_BAR0 = 2'b01;
    localparam logic [1:0] REG_BAR2 = 2'b10;

    localparam logic [5:0] REG_ID       = 6'h00;
    localparam logic [5:0] REG_DIPSW_RD = 6'h01;
    localparam logic [5:0] REG_LED      = 6'h02;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [WBE_W-1:0]  be;
        logic [DATA_W-1:0] data;
    } cmd_t;

endpackage

// File: rtl/pio_ep_mem_initiator.sv
// Requester for the endpoint register-access interface: one command in,
// one timed access on rd_*/wr_*, one response out.
module pio_ep_mem_initiator
    import pio_ep_mem_initiator_pkg::*;
#(
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned WR_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [WBE_W-1:0]  cmd_be,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [RBE_W-1:0]  rd_be,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WBE_W-1:0]  wr_be,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    input  logic              wr_busy
);

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(WR_TIMEOUT);
    localparam bit               TO_EN    = (WR_TIMEOUT != 0);

    cmd_t cmd_in;
    assign cmd_in = '{write: cmd_write, addr: cmd_addr, be: cmd_be, data: cmd_data};

    logic [ST_W-1:0]   state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [CNT_W-1:0]  to_q, to_d;
    logic              cmd_ready_d, wr_en_d;
    logic              rsp_valid_d, rsp_write_d, rsp_err_d;
    logic [DATA_W-1:0] rsp_data_d, wr_data_d;
    logic [ADDR_W-1:0] rd_addr_d, wr_addr_d;
    logic [RBE_W-1:0]  rd_be_d;
    logic [WBE_W-1:0]  wr_be_d;

    // State and registered outputs
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            lat_q     <= '0;
            to_q      <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            rd_addr   <= '0;
            rd_be     <= '0;
            wr_addr   <= '0;
            wr_be     <= '0;
            wr_data   <= '0;
            wr_en     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            to_q      <= to_d;
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_write <= rsp_write_d;
            rsp_err   <= rsp_err_d;
            rsp_data  <= rsp_data_d;
            rd_addr   <= rd_addr_d;
            rd_be     <= rd_be_d;
            wr_addr   <= wr_addr_d;
            wr_be     <= wr_be_d;
            wr_data   <= wr_data_d;
            wr_en     <= wr_en_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        to_d        = to_q;
        rsp_valid_d = rsp_valid;
        rsp_write_d = rsp_write;
        rsp_err_d   = rsp_err;
        rsp_data_d  = rsp_data;
        rd_addr_d   = rd_addr;
        rd_be_d     = rd_be;
        wr_addr_d   = wr_addr;
        wr_be_d     = wr_be;
        wr_data_d   = wr_data;
        wr_en_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    to_d = '0;
                    if (cmd_in.write) begin
                        wr_addr_d = cmd_in.addr;
                        wr_be_d   = cmd_in.be;
                        wr_data_d = cmd_in.data;
                        state_d   = ST_WR_WAIT;
                    end else begin
                        rd_addr_d = cmd_in.addr;
                        rd_be_d   = cmd_in.be[RBE_W-1:0];
                        lat_d     = LAT_INIT;
                        state_d   = ST_RD_WAIT;
                    end
                end
            end
            ST_WR_WAIT: begin
                // Strobe is decided on the same edge busy is sampled; no lookahead
                if (!wr_busy) begin
                    wr_en_d     = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = '0;
                    state_d     = ST_RSP;
                end else begin
                    to_d = to_q + CNT_W'(1);
                    if (TO_EN && (to_d == TO_LIMIT)) begin
                        rsp_valid_d = 1'b1;
                        rsp_write_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                        state_d     = ST_RSP;
                    end
                end
            end
            ST_RD_WAIT: begin
                // rd_addr stays put: the responder muxes rd_data on it combinationally
                if (lat_q == '0) begin
                    state_d = ST_RD_CAPT;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_RD_CAPT: begin
                rsp_data_d  = rd_data;
                rsp_valid_d = 1'b1;
                rsp_write_d = 1'b0;
                rsp_err_d   = 1'b0;
                state_d     = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

endmodule

// File: tb/tb_pio_ep_mem_initiator.sv
// Randomized self-checking bench: initiator against a small BAR0/BAR2 responder,
// checked by a register-level reference model.
module tb_pio_ep_mem_initiator;
    import pio_ep_mem_initiator_pkg::*;

    localparam int unsigned RD_LAT     = 1;
    localparam int unsigned WR_TIMEOUT = 4;
    localparam logic [31:0] ID_RESET   = 32'h67452301;

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [13:0] cmd_addr;
    logic [7:0]  cmd_be;
    logic [31:0] cmd_data;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
    logic [31:0] rsp_data;
    logic [13:0] rd_addr, wr_addr;
    logic [3:0]  rd_be;
    logic [31:0] rd_data, wr_data;
    logic [7:0]  wr_be;
    logic        wr_en, wr_busy;

    int checks = 0;
    int errors = 0;
    int wr_en_cnt = 0;

    always #5 clk = ~clk;

    pio_ep_mem_initiator #(.RD_LAT(RD_LAT), .WR_TIMEOUT(WR_TIMEOUT)) dut (
        .clk(clk), .sys_rst_n(sys_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_err(rsp_err), .rsp_data(rsp_data),
        .rd_addr(rd_addr), .rd_be(rd_be), .rd_data(rd_data),
        .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .wr_en(wr_en), .wr_busy(wr_busy)
    );

    // Responder: BAR0 ID/LED/DIP (DIP switches looped back to the LEDs), BAR2 scratch memory
    logic [31:0] r_id;
    logic [7:0]  r_led;
    logic [31:0] r_mem [64];
    logic [31:0] rd_pipe [RD_LAT];
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = 32'h0;
        if (rd_addr[13:12] == REG_BAR0) begin
            case (rd_addr[5:0])
                REG_ID:                rd_mux = r_id;
                REG_DIPSW_RD, REG_LED: rd_mux = {r_led, 24'h0};
                default:               rd_mux = 32'h0;
            endcase
        end else if (rd_addr[13:12] == REG_BAR2) begin
            rd_mux = r_mem[rd_addr[5:0]];
        end
    end

    always @(posedge clk) begin
        rd_pipe[0] <= rd_mux;
        for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i] && wr_addr[13:12] == REG_BAR0 && wr_addr[5:0] == REG_ID)
                    r_id[31-8*i -: 8] <= wr_data[31-8*i -: 8];
                if (wr_be[i] && wr_addr[13:12] == REG_BAR2)
                    r_mem[wr_addr[5:0]][31-8*i -: 8] <= wr_data[31-8*i -: 8];
            end
            if (wr_be[0] && wr_addr[13:12] == REG_BAR0 && wr_addr[5:0] == REG_LED)
                r_led <= wr_data[31:24];
        end
    end
    assign rd_data = rd_pipe[RD_LAT-1];

    always @(negedge clk) if (wr_en) wr_en_cnt <= wr_en_cnt + 1;

    // Reference model: register contents as bytes, lane 0 = most significant byte
    logic [7:0] m_id  [4];
    logic [7:0] m_led;
    logic [7:0] m_mem [64][4];

    function automatic logic [31:0] model_read(input logic [13:0] a);
        logic [31:0] v = 32'h0;
        if (a[13:12] == 2'b01) begin
            if (a[5:0] == 6'h00) v = {m_id[0], m_id[1], m_id[2], m_id[3]};
            else if (a[5:0] == 6'h01 || a[5:0] == 6'h02) v = {m_led, 24'h0};
        end else if (a[13:12] == 2'b10) begin
            v = {m_mem[a[5:0]][0], m_mem[a[5:0]][1], m_mem[a[5:0]][2], m_mem[a[5:0]][3]};
        end
        return v;
    endfunction

    task automatic model_write(input logic [13:0] a, input logic [7:0] be, input logic [31:0] d);
        logic [7:0] bytes [4];
        bytes[0] = d[31:24]; bytes[1] = d[23:16]; bytes[2] = d[15:8]; bytes[3] = d[7:0];
        for (int i = 0; i < 4; i++) begin
            if (!be[i]) continue;
            if (a[13:12] == 2'b01 && a[5:0] == 6'h00) m_id[i] = bytes[i];
            if (a[13:12] == 2'b01 && a[5:0] == 6'h02 && i == 0) m_led = bytes[0];
            if (a[13:12] == 2'b10) m_mem[a[5:0]][i] = bytes[i];
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full command: issue, optional busy window, response check, backpressure, handshake
    task automatic do_cmd(input logic wr, input logic [13:0] a, input logic [7:0] be,
                          input logic [31:0] d, input int busy_n, input int hold);
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat, k, wait_cnt, start_cnt;
        bit          seen;
        exp_err  = wr && (busy_n >= int'(WR_TIMEOUT));
        exp_data = wr ? 32'h0 : model_read(a);
        exp_lat  = !wr ? int'(RD_LAT) + 2 : (exp_err ? int'(WR_TIMEOUT) + 1 : busy_n + 2);
        wait_cnt = 0;
        @(negedge clk);
        while (!cmd_ready && wait_cnt < 20) begin @(negedge clk); wait_cnt++; end
        check("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
        start_cnt = wr_en_cnt;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_be = be; cmd_data = d;
        wr_busy = 1'b0;
        @(posedge clk);
        k = 0; seen = 0;
        while (!seen && k < 64) begin
            @(negedge clk); k++;
            cmd_valid = 1'b0;
            if (k == 1) check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
            if (rsp_valid) seen = 1;
            else wr_busy = wr && (k <= busy_n);
        end
        check("rsp_latency", 32'(k), 32'(exp_lat));
        check("rsp_write", 32'(rsp_write), 32'(wr));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("rsp_data", rsp_data, exp_data);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_data", rsp_data, exp_data);
            check("hold_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        wr_busy   = 1'b0;
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_cmd_ready", 32'(cmd_ready), 32'd1);
        check("wr_en_pulses", 32'(wr_en_cnt - start_cnt), 32'((wr && !exp_err) ? 1 : 0));
        if (wr && !exp_err) model_write(a, be, d);
    endtask

    initial begin
        bit          saw_rsp;
        logic [1:0]  region;
        logic        wr;
        int          busy_n;
        sys_rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_be = '0; cmd_data = '0;
        rsp_ready = 1'b0; wr_busy = 1'b0;
        r_id = ID_RESET; r_led = 8'h00;
        for (int i = 0; i < 64; i++) r_mem[i] = 32'h0;
        for (int i = 0; i < int'(RD_LAT); i++) rd_pipe[i] = 32'h0;
        m_id[0] = 8'h67; m_id[1] = 8'h45; m_id[2] = 8'h23; m_id[3] = 8'h01; m_led = 8'h00;
        for (int i = 0; i < 64; i++) for (int j = 0; j < 4; j++) m_mem[i][j] = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        sys_rst_n = 1'b1;

        do_cmd(1'b0, 14'h1000, 8'h0F, 32'h0, 0, 0);
        do_cmd(1'b1, 14'h1000, 8'h0F, 32'hEFBEADDE, 0, 0);
        do_cmd(1'b0, 14'h1000, 8'h0F, 32'h0, 0, 0);
        do_cmd(1'b1, 14'h1002, 8'h01, 32'hA5000000, 0, 1);
        check("responder_led", 32'(r_led), 32'h0000_00A5);
        do_cmd(1'b0, 14'h1001, 8'h0F, 32'h0, 0, 0);
        do_cmd(1'b1, 14'h1002, 8'h01, 32'h3C000000, 10, 0);
        do_cmd(1'b1, 14'h1002, 8'h01, 32'h5A000000, 2, 0);
        do_cmd(1'b1, 14'h1002, 8'h01, 32'h77000000, int'(WR_TIMEOUT) - 1, 0);
        do_cmd(1'b0, 14'h1002, 8'h0F, 32'h0, 0, 10);

        // Reset while a read sits in its latency wait
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 14'h1000; cmd_be = 8'h0F;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        sys_rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst_rd_addr", 32'(rd_addr), 32'd0);
        check("midrst_rd_be", 32'(rd_be), 32'd0);
        repeat (2) @(negedge clk);
        sys_rst_n = 1'b1;
        saw_rsp = 0;
        repeat (6) begin @(negedge clk); if (rsp_valid || wr_en) saw_rsp = 1; end
        check("midrst_no_rsp", 32'(saw_rsp), 32'd0);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0, 1:    region = 2'b01;
                2:       region = 2'b10;
                default: region = 2'b00;
            endcase
            wr     = 1'($urandom_range(0, 1));
            busy_n = (wr && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
            do_cmd(wr, {region, 6'h00, 6'($urandom_range(0, 7))}, 8'($urandom), $urandom,
                   busy_n, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
